// File: rtl/sram_controller_if.sv
// Request/response handshake between the load-store unit and sram_controller.
// One request in flight; resp_valid pulses once per completed transaction.
interface sram_controller_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_address, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_address, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_controller.sv
// Turns single-word requests into the active-low ce/we/oe strobe sequence of the sram
// block, owning the shared data bus with setup, pulse, hold and turnaround timing.
module sram_controller #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_controller_if.slave      req_if,
    output logic [ADDR_WIDTH-1:0] sram_address,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_chip_enable,
    output logic                  sram_write_enable,
    output logic                  sram_output_enable
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("WAIT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_SETUP,
        RD_PULSE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  ce_n_q, ce_n_d;
    logic                  we_n_q, we_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  drive_q, drive_d;
    logic                  req_ready;
    logic                  accept;

    assign req_ready  = (state_q == IDLE) && !reset;
    assign accept     = req_if.req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_if.req_address;
                    wdata_d = req_if.req_wdata;
                    state_d = req_if.req_write ? WR_SETUP : RD_SETUP;
                end
            end
            WR_SETUP: begin
                cnt_d   = CW'(WAIT_CYCLES - 1);
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HOLD: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            RD_SETUP: begin
                cnt_d   = CW'(WAIT_CYCLES - 1);
                state_d = RD_PULSE;
            end
            RD_PULSE: begin
                if (cnt_q == '0) begin
                    rdata_d      = sram_data;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state and registered so the pins never glitch.
        ce_n_d  = (state_d == IDLE);
        we_n_d  = (state_d != WR_PULSE);
        oe_n_d  = (state_d != RD_PULSE);
        drive_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            ce_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            drive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            ce_n_q       <= ce_n_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            drive_q      <= drive_d;
        end
    end

    assign req_if.req_ready   = req_ready;
    assign req_if.resp_valid  = resp_valid_q;
    assign req_if.resp_rdata  = rdata_q;
    assign sram_address       = addr_q;
    assign sram_chip_enable   = ce_n_q;
    assign sram_write_enable  = we_n_q;
    assign sram_output_enable = oe_n_q;
    assign sram_data          = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (WAIT_CYCLES 1 and 3), each with a
// small behavioural async SRAM on its own bus.
module tb_sram_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    sram_controller_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if1 ();
    sram_controller_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if3 ();

    wire  [15:0] bus1, bus3;
    logic [7:0]  addr1, addr3;
    logic        ce1, we1, oe1, ce3, we3, oe3;
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];

    sram_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req_if(if1), .sram_address(addr1), .sram_data(bus1),
        .sram_chip_enable(ce1), .sram_write_enable(we1), .sram_output_enable(oe1)
    );

    sram_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .req_if(if3), .sram_address(addr3), .sram_data(bus3),
        .sram_chip_enable(ce3), .sram_write_enable(we3), .sram_output_enable(oe3)
    );

    assign bus1 = (!ce1 && !oe1) ? mem1[addr1] : 16'bz;
    assign bus3 = (!ce3 && !oe3) ? mem3[addr3] : 16'bz;
    always @(posedge we1) if (!ce1) mem1[addr1] = bus1;
    always @(posedge we3) if (!ce3) mem3[addr3] = bus3;

    // Continuous protocol watch on the WAIT_CYCLES=1 instance.
    int idle1 = 100;
    logic oe1_prev = 1'b1;
    logic rv1_prev = 1'b0;
    int resp1_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!we1 && !oe1) begin
                errors++;
                $display("FAIL strobe_overlap we_n=%b oe_n=%b required not both 0 at %0t", we1, oe1, $time);
            end
            checks++;
            if (dut1.drive_q && !oe1) begin
                errors++;
                $display("FAIL drive_with_oe drive=%b oe_n=%b required no drive while oe_n 0", dut1.drive_q, oe1);
            end
            if (oe1_prev && !oe1) begin
                checks++;
                if (idle1 < 2) begin
                    errors++;
                    $display("FAIL turnaround idle_cycles=%0d required >=2", idle1);
                end
            end
            if (if1.resp_valid) begin
                checks++;
                if (rv1_prev) begin
                    errors++;
                    $display("FAIL resp_pulse_width resp_valid high 2 cycles required 1");
                end
                if (!rv1_prev) resp1_cnt++;
            end
            idle1 = dut1.drive_q ? 0 : idle1 + 1;
        end
        oe1_prev = oe1;
        rv1_prev = if1.resp_valid;
    end

    task automatic txn1(input bit wr, input logic [7:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd);
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_write = wr; if1.req_address = a; if1.req_wdata = d;
        checks++;
        if (if1.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_txn got %b required 1", if1.req_ready);
        end
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if1.resp_valid && lat < 20);
        rd = if1.resp_rdata;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ce1, we1, oe1} !== 3'b111 || addr1 !== 8'h00 || if1.resp_valid !== 1'b0 ||
            if1.resp_rdata !== 16'h0000 || if1.req_ready !== 1'b0 || dut1.drive_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_values ce/we/oe=%b%b%b addr=%h rv=%b rdata=%h ready=%b drive=%b required 111 00 0 0000 0 0",
                     ce1, we1, oe1, addr1, if1.resp_valid, if1.resp_rdata, if1.req_ready, dut1.drive_q);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if1.req_ready !== 1'b1 || if3.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b/%b required 1/1", if1.req_ready, if3.req_ready);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd;
        txn1(1'b1, 8'h10, 16'hBEEF, lat, rd);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL write_latency got %0d required 3", lat); end
        txn1(1'b0, 8'h10, 16'h0000, lat, rd);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL read_latency got %0d required 2", lat); end
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL read_beef got %h required beef", rd); end
        checks++;
        if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL ready_with_resp got %b required 1", if1.req_ready); end
    endtask

    task automatic test_addr_extremes();
        int lat; logic [15:0] rd;
        txn1(1'b1, 8'h00, 16'hFFFF, lat, rd);
        txn1(1'b1, 8'hFF, 16'h0000, lat, rd);
        txn1(1'b0, 8'h00, 16'h1234, lat, rd);
        checks++;
        if (rd !== 16'hFFFF) begin errors++; $display("FAIL read_addr00 got %h required ffff", rd); end
        txn1(1'b0, 8'hFF, 16'h1234, lat, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL read_addrff got %h required 0000", rd); end
    endtask

    task automatic test_back_to_back();
        bit          wr  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  ad  [6] = '{8'h20, 8'h20, 8'h21, 8'h21, 8'h22, 8'h22};
        logic [15:0] dat [6] = '{16'h1357, 16'h0, 16'h2468, 16'h0, 16'h9ABC, 16'h0};
        logic [15:0] exp_rd [6] = '{16'h0, 16'h1357, 16'h0, 16'h2468, 16'h0, 16'h9ABC};
        int lat;
        int start_cnt = resp1_cnt;
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_write = wr[0]; if1.req_address = ad[0]; if1.req_wdata = dat[0];
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k < 5) begin
                if1.req_write = wr[k+1]; if1.req_address = ad[k+1]; if1.req_wdata = dat[k+1];
            end else begin
                if1.req_valid = 1'b0;
            end
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!if1.resp_valid && lat < 20);
            checks++;
            if (lat != (wr[k] ? 3 : 2)) begin
                errors++;
                $display("FAIL b2b_latency item %0d got %0d required %0d", k, lat, wr[k] ? 3 : 2);
            end
            if (!wr[k]) begin
                checks++;
                if (if1.resp_rdata !== exp_rd[k]) begin
                    errors++;
                    $display("FAIL b2b_rdata item %0d got %h required %h", k, if1.resp_rdata, exp_rd[k]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (resp1_cnt - start_cnt != 6) begin
            errors++;
            $display("FAIL b2b_resp_count got %0d required 6", resp1_cnt - start_cnt);
        end
    endtask

    task automatic test_input_change_mid_write();
        int lat; logic [15:0] rd;
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_address = 8'h33; if1.req_wdata = 16'hA5A5;
        @(posedge clk); #1;
        if1.req_valid = 1'b0; if1.req_address = 8'h44; if1.req_wdata = 16'h1111;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (addr1 !== 8'h33 || bus1 !== 16'hA5A5) begin
                errors++;
                $display("FAIL hold_addr_data cycle %0d got %h/%h required 33/a5a5", c, addr1, bus1);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (if1.resp_valid !== 1'b1) begin errors++; $display("FAIL hold_write_resp got %b required 1", if1.resp_valid); end
        txn1(1'b0, 8'h33, 16'h0, lat, rd);
        checks++;
        if (rd !== 16'hA5A5) begin errors++; $display("FAIL hold_readback got %h required a5a5", rd); end
    endtask

    task automatic test_reset_mid_write();
        bit saw_resp = 1'b0;
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_address = 8'h50; if1.req_wdata = 16'h1234;
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (we1 !== 1'b0) begin errors++; $display("FAIL in_wr_pulse we_n got %b required 0", we1); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ce1, we1, oe1} !== 3'b111 || dut1.drive_q !== 1'b0 || addr1 !== 8'h00 || if1.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset ce/we/oe=%b%b%b drive=%b addr=%h ready=%b required 111 0 00 0",
                     ce1, we1, oe1, dut1.drive_q, addr1, if1.req_ready);
        end
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (if1.resp_valid) saw_resp = 1'b1;
            if (c == 0) begin
                checks++;
                if (if1.req_ready !== 1'b1 || {ce1, we1, oe1} !== 3'b111 || if1.resp_rdata !== 16'h0000) begin
                    errors++;
                    $display("FAIL post_reset ready=%b strobes=%b%b%b rdata=%h required 1 111 0000",
                             if1.req_ready, ce1, we1, oe1, if1.resp_rdata);
                end
            end
        end
        checks++;
        if (saw_resp) begin errors++; $display("FAIL dropped_txn_resp got resp_valid 1 required none"); end
    endtask

    task automatic test_wait3();
        int lat; int low;
        @(negedge clk);
        if3.req_valid = 1'b1; if3.req_write = 1'b1; if3.req_address = 8'h77; if3.req_wdata = 16'hC0DE;
        @(posedge clk); #1;
        if3.req_valid = 1'b0;
        lat = 0; low = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!we3) low++;
            if (!we3 && !oe3) begin errors++; $display("FAIL w3_overlap we_n=0 oe_n=0"); end
        end while (!if3.resp_valid && lat < 20);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL w3_write_latency got %0d required 5", lat); end
        checks++;
        if (low != 3) begin errors++; $display("FAIL w3_we_width got %0d required 3", low); end
        @(negedge clk);
        if3.req_valid = 1'b1; if3.req_write = 1'b0; if3.req_address = 8'h77;
        @(posedge clk); #1;
        if3.req_valid = 1'b0;
        lat = 0; low = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!oe3) low++;
        end while (!if3.resp_valid && lat < 20);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL w3_read_latency got %0d required 4", lat); end
        checks++;
        if (low != 3) begin errors++; $display("FAIL w3_oe_width got %0d required 3", low); end
        checks++;
        if (if3.resp_rdata !== 16'hC0DE) begin errors++; $display("FAIL w3_rdata got %h required c0de", if3.resp_rdata); end
    endtask

    initial begin
        if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_address = '0; if1.req_wdata = '0;
        if3.req_valid = 1'b0; if3.req_write = 1'b0; if3.req_address = '0; if3.req_wdata = '0;
        test_reset();
        test_write_read();
        test_addr_extremes();
        test_back_to_back();
        test_input_change_mid_write();
        test_wait3();
        test_reset_mid_write();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
